onehot_rr_arbiter: RTL and testbench

ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

---
 rtl/onehot_pkg.sv | 18 +
 rtl/onehot_rr_arbiter_rr_pick.sv | 30 +++
 rtl/onehot_rr_arbiter.sv | 109 ++++++++++
 tb/tb_onehot_rr_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot round-robin arbiter: default requester
// count, pointer width and the two-state FSM encoding.
package onehot_pkg;

  localparam int ARB_N_DEF = 8;
  localparam int ARB_PTR_W = $clog2(ARB_N_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  // Pointer width for an N-requester arbiter (N is always at least 2).
  function automatic int arb_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or above ptr,
// wrapping from N-1 to 0. Returns a one-hot winner and a found flag.
module rr_pick
  import onehot_pkg::*;
#(
  parameter int N  = ARB_N_DEF,
  parameter int PW = arb_ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          found
);

  logic [PW-1:0] w_idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    w_idx  = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((32'(ptr) + 32'(k)) % 32'(N));
      if (!found && req[w_idx]) begin
        winner[w_idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// One-hot round-robin arbiter with a valid/ready grant handshake.
// Optional macro ARB_LOCK_EN adds a lock input that lets the winner keep the grant.
//
// state | meaning
// IDLE  | no grant offered, waiting for any request
// OFFER | grant/grant_valid held stable until grant_ready
module onehot_rr_arbiter
  import onehot_pkg::*;
#(
  parameter int N = ARB_N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
`ifdef ARB_LOCK_EN
  input  logic         lock,
`endif
  input  logic         grant_ready,
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  localparam int PW = arb_ptr_w(N);

  arb_state_e    r_state;
  logic [N-1:0]  r_grant;
  logic          r_grant_valid;
  logic [PW-1:0] r_ptr;

  logic          w_handshake;
  logic          w_hold;
  logic [PW-1:0] w_win_idx;
  logic [PW-1:0] w_ptr_adv;
  logic [PW-1:0] w_ptr_nxt;
  logic [N-1:0]  w_winner;
  logic          w_found;

  assign w_handshake = r_grant_valid & grant_ready;

`ifdef ARB_LOCK_EN
  // Lock only matters while the current winner is still requesting.
  assign w_hold = lock & (|(req & r_grant));
`else
  assign w_hold = 1'b0;
`endif

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) w_win_idx = PW'(i);
    end
  end

  assign w_ptr_adv = (w_win_idx == PW'(N - 1)) ? '0 : (w_win_idx + PW'(1));

  // Search from the post-handshake pointer so back-to-back grants rotate.
  assign w_ptr_nxt = (w_handshake && !w_hold) ? w_ptr_adv : r_ptr;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req    (req),
    .ptr    (w_ptr_nxt),
    .winner (w_winner),
    .found  (w_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_ptr         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state       <= OFFER;
            r_grant       <= w_winner;
            r_grant_valid <= 1'b1;
          end
        end
        OFFER: begin
          if (w_handshake && !w_hold) begin
            r_ptr <= w_ptr_adv;
            if (w_found) begin
              r_grant <= w_winner;
            end else begin
              r_state       <= IDLE;
              r_grant       <= '0;
              r_grant_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state       <= IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_ptr         <= '0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed bench for onehot_rr_arbiter (N=8); lock scenario only when ARB_LOCK_EN is defined.
module tb_onehot_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       grant_ready;
  logic [7:0] grant;
  logic       grant_valid;
`ifdef ARB_LOCK_EN
  logic       lock;
`endif

  int n_total;
  int n_pass;

  onehot_rr_arbiter #(.N(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
`ifdef ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant_ready (grant_ready),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g, input logic v);
    chk({tag, "_grant"}, grant, g);
    chk({tag, "_valid"}, {7'd0, grant_valid}, {7'd0, v});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0;
    req = 8'h00;
    grant_ready = 1'b0;
`ifdef ARB_LOCK_EN
    lock = 1'b0;
`endif
    #3;
    chk_out("reset", 8'h00, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("idle_noreq", 8'h00, 1'b0);

    // Reset while an offer is pending drops it immediately.
    req = 8'h10;
    tick();
    chk_out("offer_10", 8'h10, 1'b1);
    rst_n = 1'b0;
    #2;
    chk_out("reset_mid_offer", 8'h00, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("after_reset_10", 8'h10, 1'b1);
    grant_ready = 1'b1;
    tick();
    chk_out("single_req_regrant", 8'h10, 1'b1);
    req = 8'h00;
    tick();
    chk_out("hs_noreq_idle", 8'h00, 1'b0);
    grant_ready = 1'b0;

    // Full rotation from ptr=0.
    do_reset();
    req = 8'hFF;
    tick();
    chk_out("rot_first", 8'h01, 1'b1);
    grant_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] exp_g;
      exp_g = 8'h01 << (i % 8);
      tick();
      chk_out($sformatf("rot_%0d", i), exp_g, 1'b1);
      chk($sformatf("rot_onehot_%0d", i), {7'd0, $countones(grant) == 1}, 8'h01);
    end
    req = 8'h00;
    tick();
    chk_out("rot_drain", 8'h00, 1'b0);
    grant_ready = 1'b0;

    // Stall: ptr=1, req=24 -> 04 held, then 20.
    req = 8'h24;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("stall_%0d", i), 8'h04, 1'b1);
    end
    grant_ready = 1'b1;
    tick();
    chk_out("stall_next", 8'h20, 1'b1);
    req = 8'h00;
    tick();
    chk_out("stall_drain", 8'h00, 1'b0);
    grant_ready = 1'b0;

    // Wrap: ptr=6, grant 40, then req=41 -> 01.
    req = 8'h40;
    tick();
    chk_out("wrap_40", 8'h40, 1'b1);
    req = 8'h41;
    grant_ready = 1'b1;
    tick();
    chk_out("wrap_01", 8'h01, 1'b1);
    req = 8'h00;
    tick();
    chk_out("wrap_drain", 8'h00, 1'b0);
    grant_ready = 1'b0;

    // Request drop while stalled: grant held until handshake.
    req = 8'h08;
    tick();
    chk_out("drop_offer", 8'h08, 1'b1);
    req = 8'h00;
    tick();
    chk_out("drop_hold1", 8'h08, 1'b1);
    tick();
    chk_out("drop_hold2", 8'h08, 1'b1);
    grant_ready = 1'b1;
    tick();
    chk_out("drop_release", 8'h00, 1'b0);

    // Ready while idle is ignored; ptr=4 here.
    tick();
    chk_out("ready_idle", 8'h00, 1'b0);
    req = 8'h22;
    tick();
    chk_out("idle_pick_20", 8'h20, 1'b1);
    tick();
    chk_out("wrap_pick_02", 8'h02, 1'b1);
    req = 8'h00;
    tick();
    chk_out("final_drain", 8'h00, 1'b0);
    grant_ready = 1'b0;

`ifdef ARB_LOCK_EN
    do_reset();
    req = 8'h06;
    lock = 1'b1;
    tick();
    chk_out("lock_first", 8'h02, 1'b1);
    grant_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("lock_hold_%0d", i), 8'h02, 1'b1);
    end
    lock = 1'b0;
    tick();
    chk_out("lock_release", 8'h04, 1'b1);
    req = 8'h00;
    tick();
    chk_out("lock_drain", 8'h00, 1'b0);
    grant_ready = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
